// File: rtl/demux4_buffered_pkg.sv
// Shared constants for the four-way buffered demultiplexer and its selector-side
// counterpart. Also holds the select decoder used to build the one-hot load.
package demux4_buffered_pkg;

  localparam int NUM_CHANNELS = 4;
  localparam int SEL_WIDTH    = 2;
  localparam int COUNT_WIDTH  = 8;

  typedef logic [SEL_WIDTH-1:0]    sel_t;
  typedef logic [NUM_CHANNELS-1:0] chan_mask_t;
  typedef logic [COUNT_WIDTH-1:0]  count_t;

  // Turn a channel number into a one-hot channel mask.
  function automatic chan_mask_t sel_decode(input sel_t sel);
    chan_mask_t mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux4_buffered_if.sv
// Producer-side and consumer-side signals of the buffered demultiplexer.
// The slave modport is the demux itself; master is whoever drives it.
interface demux4_buffered_if
  import demux4_buffered_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] in_data;
  sel_t             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  chan_mask_t       out_valid;
  chan_mask_t       out_ready;
  count_t           xfer_count;

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, y0, y1, y2, y3, out_valid, xfer_count
  );

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, y0, y1, y2, y3, out_valid, xfer_count
  );

endinterface

// File: rtl/demux4_buffered_slot.sv
// One output channel: a single-entry holding register with a valid flag.
// A load always wins over a drain on the same edge, so a channel that is
// emptied and refilled together never shows a gap in valid.
module demux_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  // Capture a new word on load, otherwise clear valid once the consumer takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux4_buffered.sv
// Four-way registered demultiplexer. Routes one input word per cycle into one
// of four single-entry channels and counts accepted words modulo 256.
module demux4_buffered
  import demux4_buffered_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic               clock,
  input logic               reset,
  demux4_buffered_if.slave  bus
);

  logic [WIDTH-1:0] y_q [NUM_CHANNELS];
  chan_mask_t       valid_q;
  chan_mask_t       load;
  count_t           count_q;
  logic             ready_int;
  logic             accept;

  // The addressed channel can take a word if it is empty or draining this cycle.
  always_comb begin
    ready_int = !reset && (!valid_q[bus.in_sel] || bus.out_ready[bus.in_sel]);
    accept    = bus.in_valid && ready_int;
    load      = accept ? sel_decode(bus.in_sel) : '0;
  end

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clock (clock),
      .reset (reset),
      .load  (load[k]),
      .d     (bus.in_data),
      .ready (bus.out_ready[k]),
      .q     (y_q[k]),
      .valid (valid_q[k])
    );
  end

  // Count every accepted word; natural overflow gives the modulo-256 wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.in_ready   = ready_int;
  assign bus.y0         = y_q[0];
  assign bus.y1         = y_q[1];
  assign bus.y2         = y_q[2];
  assign bus.y3         = y_q[3];
  assign bus.out_valid  = valid_q;
  assign bus.xfer_count = count_q;

endmodule

// File: tb/tb_demux4_buffered.sv
// Directed bench for demux4_buffered: reset, routing, back-pressure,
// channel independence, counter wrap and mid-operation reset.
module tb_demux4_buffered;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  demux4_buffered_if #(.WIDTH(4)) bus ();

  demux4_buffered #(.WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic apply_stimulus(input logic v, input logic [1:0] sel,
                                input logic [3:0] data, input logic [3:0] rdy);
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = data;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Single linear directed sequence.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    apply_stimulus(1'b1, 2'd0, 4'h7, 4'b0000);
    step();
    step();
    check_output("rst_y0", bus.y0, 4'h0);
    check_output("rst_y1", bus.y1, 4'h0);
    check_output("rst_y2", bus.y2, 4'h0);
    check_output("rst_y3", bus.y3, 4'h0);
    check_output("rst_valid", bus.out_valid, 4'b0000);
    check_output("rst_ready", bus.in_ready, 1'b0);
    check_output("rst_count", bus.xfer_count, 8'd0);

    // Routing with all consumers ready
    reset = 1'b0;
    apply_stimulus(1'b1, 2'd0, 4'h0, 4'b1111);
    check_output("route0_ready", bus.in_ready, 1'b1);
    step();
    check_output("route0_valid", bus.out_valid, 4'b0001);
    check_output("route0_y0", bus.y0, 4'h0);
    check_output("route0_count", bus.xfer_count, 8'd1);
    apply_stimulus(1'b1, 2'd1, 4'h1, 4'b1111);
    step();
    check_output("route1_valid", bus.out_valid, 4'b0010);
    check_output("route1_y1", bus.y1, 4'h1);
    apply_stimulus(1'b1, 2'd2, 4'h5, 4'b1111);
    step();
    check_output("route2_valid", bus.out_valid, 4'b0100);
    check_output("route2_y2", bus.y2, 4'h5);
    apply_stimulus(1'b1, 2'd3, 4'hF, 4'b1111);
    step();
    check_output("route3_valid", bus.out_valid, 4'b1000);
    check_output("route3_y3", bus.y3, 4'hF);
    check_output("route_count", bus.xfer_count, 8'd4);
    apply_stimulus(1'b0, 2'd0, 4'h0, 4'b1111);
    step();
    check_output("idle_valid", bus.out_valid, 4'b0000);
    check_output("idle_count", bus.xfer_count, 8'd4);

    // Back-pressure on channel 2
    apply_stimulus(1'b1, 2'd2, 4'h5, 4'b1011);
    check_output("bp_first_ready", bus.in_ready, 1'b1);
    step();
    check_output("bp_first_valid", bus.out_valid, 4'b0100);
    check_output("bp_first_y2", bus.y2, 4'h5);
    apply_stimulus(1'b1, 2'd2, 4'hA, 4'b1011);
    check_output("bp_stall_ready", bus.in_ready, 1'b0);
    step();
    check_output("bp_stall_y2", bus.y2, 4'h5);
    check_output("bp_stall_valid", bus.out_valid, 4'b0100);
    check_output("bp_stall_count", bus.xfer_count, 8'd5);
    apply_stimulus(1'b1, 2'd2, 4'hA, 4'b1111);
    check_output("bp_release_ready", bus.in_ready, 1'b1);
    step();
    check_output("bp_release_y2", bus.y2, 4'hA);
    check_output("bp_release_valid", bus.out_valid, 4'b0100);
    check_output("bp_release_count", bus.xfer_count, 8'd6);

    // Independence: channel 1 full and stalled, channel 3 still accepts
    apply_stimulus(1'b1, 2'd1, 4'h9, 4'b0000);
    step();
    check_output("ind_fill_valid", bus.out_valid, 4'b0110);
    check_output("ind_fill_y1", bus.y1, 4'h9);
    apply_stimulus(1'b0, 2'd1, 4'h0, 4'b0000);
    check_output("ind_ch1_ready", bus.in_ready, 1'b0);
    apply_stimulus(1'b1, 2'd3, 4'h3, 4'b0000);
    check_output("ind_ch3_ready", bus.in_ready, 1'b1);
    step();
    check_output("ind_valid", bus.out_valid, 4'b1110);
    check_output("ind_y3", bus.y3, 4'h3);
    check_output("ind_y1", bus.y1, 4'h9);
    check_output("ind_count", bus.xfer_count, 8'd8);
    apply_stimulus(1'b0, 2'd0, 4'h0, 4'b1111);
    step();
    check_output("drain_all_valid", bus.out_valid, 4'b0000);
    check_output("drain_hold_y3", bus.y3, 4'h3);

    // Counter wrap: 248 more accepts brings the count from 8 to 256 -> 0
    for (int i = 0; i < 248; i++) begin
      apply_stimulus(1'b1, 2'd0, 4'(i), 4'b1111);
      step();
    end
    check_output("wrap_count0", bus.xfer_count, 8'd0);
    check_output("wrap_y0", bus.y0, 4'h7);
    apply_stimulus(1'b1, 2'd0, 4'hC, 4'b1111);
    step();
    check_output("wrap_count1", bus.xfer_count, 8'd1);
    check_output("wrap_y0_last", bus.y0, 4'hC);

    // Reset mid-operation with channels 0 and 3 full
    apply_stimulus(1'b1, 2'd3, 4'h6, 4'b0000);
    step();
    check_output("pre_rst_valid", bus.out_valid, 4'b1001);
    check_output("pre_rst_count", bus.xfer_count, 8'd2);
    reset = 1'b1;
    apply_stimulus(1'b1, 2'd1, 4'h2, 4'b0000);
    check_output("mid_rst_ready", bus.in_ready, 1'b0);
    step();
    check_output("mid_rst_valid", bus.out_valid, 4'b0000);
    check_output("mid_rst_count", bus.xfer_count, 8'd0);
    check_output("mid_rst_y3", bus.y3, 4'h0);
    check_output("mid_rst_y1", bus.y1, 4'h0);
    reset = 1'b0;
    apply_stimulus(1'b0, 2'd0, 4'h0, 4'b0000);
    step();
    check_output("post_rst_valid", bus.out_valid, 4'b0000);
    check_output("post_rst_count", bus.xfer_count, 8'd0);
    apply_stimulus(1'b1, 2'd2, 4'hB, 4'b0000);
    step();
    check_output("post_rst_acc_valid", bus.out_valid, 4'b0100);
    check_output("post_rst_acc_y2", bus.y2, 4'hB);
    check_output("post_rst_acc_count", bus.xfer_count, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
